// File: rtl/io_port_responder.sv
// Device-side end of the core's 8-bit I/O port: core writes go into a TX FIFO,
// core reads come from an RX FIFO. Both FIFOs connect to external valid/ready streams.
module io_port_fifo #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] head_data,
   output logic       empty,
   output logic       full
);
   localparam int                   DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            mem [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] head, tail;
   logic [DEPTH_LOG2:0]   count;

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
      end
   end

   // Storage is not reset; the empty gating below hides stale entries.
   always_ff @(posedge clock) begin
      if (push) mem[tail] <= wdata;
   end

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign head_data = empty ? 8'h00 : mem[head];
endmodule

module io_port_responder #(
   parameter int DEPTH_LOG2  = 2,
   parameter bit STROBE_EDGE = 1'b1,
   parameter bit INT_ENABLE  = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] io_wdata,
   input  logic       io_write,
   input  logic       io_read,
   output logic [7:0] io_rdata,
   output logic       int_req,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       tx_overflow,
   output logic       rx_underflow,
   input  logic       flag_clear
);
   localparam int TX = 0;
   localparam int RX = 1;

   logic             io_write_q, io_read_q;
   logic             wr_op, rd_op;
   logic [1:0]       push, pop, empty, full;
   logic [1:0][7:0]  wdata, head;

   // History regs come out of reset high in edge mode so a strobe held across
   // reset release must drop before it can fire.
   always_ff @(posedge clock) begin
      if (reset) begin
         io_write_q <= STROBE_EDGE;
         io_read_q  <= STROBE_EDGE;
      end else begin
         io_write_q <= io_write;
         io_read_q  <= io_read;
      end
   end

   assign wr_op = io_write & (~io_write_q | ~STROBE_EDGE);
   assign rd_op = io_read  & (~io_read_q  | ~STROBE_EDGE);

   assign tx_valid  = ~empty[TX];
   assign pop[TX]   = tx_valid & tx_ready;
   assign push[TX]  = wr_op & (~full[TX] | pop[TX]);
   assign wdata[TX] = io_wdata;
   assign tx_data   = head[TX];

   assign rx_ready  = ~full[RX] | rd_op;
   assign push[RX]  = rx_valid & rx_ready;
   assign pop[RX]   = rd_op & ~empty[RX];
   assign wdata[RX] = rx_data;
   assign io_rdata  = head[RX];

   genvar g;
   for (g = 0; g < 2; g++) begin : g_fifo
      io_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
         .clock     (clock),
         .reset     (reset),
         .push      (push[g]),
         .pop       (pop[g]),
         .wdata     (wdata[g]),
         .head_data (head[g]),
         .empty     (empty[g]),
         .full      (full[g])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_overflow  <= 1'b0;
         rx_underflow <= 1'b0;
      end else begin
         tx_overflow  <= (wr_op & full[TX] & ~pop[TX]) | (tx_overflow  & ~flag_clear);
         rx_underflow <= (rd_op & empty[RX])           | (rx_underflow & ~flag_clear);
      end
   end

   // The RX count register already holds last cycle's next-count, so its
   // non-empty decode is the registered form of (rx_count_next != 0).
   assign int_req = INT_ENABLE & ~empty[RX];
endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: edge-mode DUT plus a level-mode copy
// sharing the same stimulus for the strobe-qualify scenario.
module tb_io_port_responder;
   logic       clock = 1'b0;
   logic       reset, io_write, io_read, tx_ready, rx_valid, flag_clear;
   logic [7:0] io_wdata, rx_data;
   logic [7:0] io_rdata, tx_data, io_rdata0, tx_data0;
   logic       int_req, tx_valid, rx_ready, tx_overflow, rx_underflow;
   logic       int_req0, tx_valid0, rx_ready0, tx_overflow0, rx_underflow0;
   int         passed = 0;
   int         total  = 0;

   always #5 clock = ~clock;

   io_port_responder dut (
      .clock(clock), .reset(reset), .io_wdata(io_wdata), .io_write(io_write),
      .io_read(io_read), .io_rdata(io_rdata), .int_req(int_req), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_overflow(tx_overflow), .rx_underflow(rx_underflow),
      .flag_clear(flag_clear));

   io_port_responder #(.STROBE_EDGE(1'b0)) dut0 (
      .clock(clock), .reset(reset), .io_wdata(io_wdata), .io_write(io_write),
      .io_read(io_read), .io_rdata(io_rdata0), .int_req(int_req0), .tx_data(tx_data0),
      .tx_valid(tx_valid0), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready0), .tx_overflow(tx_overflow0), .rx_underflow(rx_underflow0),
      .flag_clear(flag_clear));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      io_write = 0; io_read = 0; tx_ready = 0; rx_valid = 0; flag_clear = 0;
      io_wdata = 0; rx_data = 0;
      reset = 1;
      tick(); tick();
      reset = 0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else passed++;
      total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else passed++;
      total++; if (io_rdata !== 8'h00) $display("FAIL reset_io_rdata got %h exp 00", io_rdata); else passed++;
      total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b exp 1", rx_ready); else passed++;
      total++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b exp 0", int_req); else passed++;
      total++; if ({tx_overflow, rx_underflow} !== 2'b00)
         $display("FAIL reset_flags got %b exp 00", {tx_overflow, rx_underflow}); else passed++;
   endtask

   task automatic test_tx_basic();
      do_reset();
      io_wdata = 8'h5A; io_write = 1;
      tick();
      io_write = 0;
      total++; if (tx_valid !== 1'b1) $display("FAIL tx_basic_valid got %b exp 1", tx_valid); else passed++;
      total++; if (tx_data !== 8'h5A) $display("FAIL tx_basic_data got %h exp 5a", tx_data); else passed++;
      tx_ready = 1;
      tick();
      tx_ready = 0;
      total++; if (tx_valid !== 1'b0) $display("FAIL tx_basic_drained got %b exp 0", tx_valid); else passed++;
      total++; if (tx_data !== 8'h00) $display("FAIL tx_basic_data_empty got %h exp 00", tx_data); else passed++;
   endtask

   task automatic test_strobe();
      int n_edge, n_level;
      do_reset();
      io_wdata = 8'h11; io_write = 1;
      tick(); tick(); tick();
      io_write = 0;
      tick();
      n_edge = 0; n_level = 0;
      tx_ready = 1;
      for (int i = 0; i < 6; i++) begin
         if (tx_valid  && tx_data  == 8'h11) n_edge++;
         if (tx_valid0 && tx_data0 == 8'h11) n_level++;
         tick();
      end
      tx_ready = 0;
      total++; if (n_edge !== 1) $display("FAIL strobe_edge_entries got %0d exp 1", n_edge); else passed++;
      total++; if (n_level !== 3) $display("FAIL strobe_level_entries got %0d exp 3", n_level); else passed++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         io_wdata = 8'(i); io_write = 1;
         tick();
         io_write = 0;
         tick();
      end
      total++; if (tx_overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", tx_overflow); else passed++;
      total++; if (tx_data !== 8'h01) $display("FAIL ovf_head got %h exp 01", tx_data); else passed++;
      // overflow and clear in the same cycle: set wins
      io_wdata = 8'h06; io_write = 1; flag_clear = 1;
      tick();
      io_write = 0; flag_clear = 0;
      total++; if (tx_overflow !== 1'b1) $display("FAIL ovf_set_beats_clear got %b exp 1", tx_overflow); else passed++;
      tx_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         total++; if (tx_data !== 8'(i)) $display("FAIL ovf_drain_%0d got %h exp %h", i, tx_data, 8'(i)); else passed++;
         tick();
      end
      tx_ready = 0;
      total++; if (tx_valid !== 1'b0) $display("FAIL ovf_drained got %b exp 0", tx_valid); else passed++;
      flag_clear = 1;
      tick();
      flag_clear = 0;
      total++; if (tx_overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", tx_overflow); else passed++;
   endtask

   task automatic test_rx_int();
      do_reset();
      rx_data = 8'hA0; rx_valid = 1;
      tick();
      total++; if (int_req !== 1'b1) $display("FAIL int_rise got %b exp 1", int_req); else passed++;
      rx_data = 8'hA1;
      tick();
      rx_valid = 0;
      io_read = 1; #1;
      total++; if (io_rdata !== 8'hA0) $display("FAIL rx_read0 got %h exp a0", io_rdata); else passed++;
      tick();
      io_read = 0;
      tick();
      total++; if (int_req !== 1'b1) $display("FAIL int_held got %b exp 1", int_req); else passed++;
      io_read = 1; #1;
      total++; if (io_rdata !== 8'hA1) $display("FAIL rx_read1 got %h exp a1", io_rdata); else passed++;
      tick();
      io_read = 0;
      total++; if (int_req !== 1'b0) $display("FAIL int_fall got %b exp 0", int_req); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [4];
      exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hEE};
      do_reset();
      rx_valid = 1;
      for (int i = 0; i < 4; i++) begin
         rx_data = 8'hB0 + 8'(i);
         tick();
      end
      rx_valid = 0; #1;
      total++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b exp 0", rx_ready); else passed++;
      rx_data = 8'hEE; rx_valid = 1; io_read = 1; #1;
      total++; if (rx_ready !== 1'b1) $display("FAIL rx_full_pop_ready got %b exp 1", rx_ready); else passed++;
      total++; if (io_rdata !== 8'hB0) $display("FAIL rx_full_pop_data got %h exp b0", io_rdata); else passed++;
      tick();
      rx_valid = 0; io_read = 0; #1;
      total++; if (rx_ready !== 1'b0) $display("FAIL rx_still_full got %b exp 0", rx_ready); else passed++;
      tick();
      for (int i = 0; i < 4; i++) begin
         io_read = 1; #1;
         total++; if (io_rdata !== exp_q[i]) $display("FAIL rx_drain_%0d got %h exp %h", i, io_rdata, exp_q[i]); else passed++;
         tick();
         io_read = 0;
         tick();
      end
      total++; if ({rx_ready, int_req} !== 2'b10)
         $display("FAIL rx_drained got %b exp 10", {rx_ready, int_req}); else passed++;
   endtask

   task automatic test_underflow_reset();
      do_reset();
      io_read = 1; #1;
      total++; if (io_rdata !== 8'h00) $display("FAIL udf_rdata got %h exp 00", io_rdata); else passed++;
      tick();
      io_read = 0;
      total++; if (rx_underflow !== 1'b1) $display("FAIL udf_set got %b exp 1", rx_underflow); else passed++;
      total++; if (int_req !== 1'b0) $display("FAIL udf_no_int got %b exp 0", int_req); else passed++;
      rx_data = 8'hC0; rx_valid = 1;
      tick(); tick();
      io_wdata = 8'h77; io_write = 1;
      tick();
      total++; if ({tx_valid, int_req} !== 2'b11)
         $display("FAIL midfill_state got %b exp 11", {tx_valid, int_req}); else passed++;
      io_write = 0;
      tick();
      io_write = 1; reset = 1;
      tick();
      total++; if ({tx_valid, int_req, tx_overflow, rx_underflow} !== 4'b0000)
         $display("FAIL midreset_state got %b exp 0000", {tx_valid, int_req, tx_overflow, rx_underflow}); else passed++;
      total++; if ({rx_ready, io_rdata, tx_data} !== {1'b1, 16'h0000})
         $display("FAIL midreset_outputs got %h exp 10000", {rx_ready, io_rdata, tx_data}); else passed++;
      reset = 0; rx_valid = 0;
      tick(); tick();
      total++; if (tx_valid !== 1'b0) $display("FAIL held_strobe_ignored got %b exp 0", tx_valid); else passed++;
      io_write = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_strobe();
      test_overflow();
      test_rx_int();
      test_back_to_back();
      test_underflow_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
